// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - mode encodings, slot index and active-low seven-segment glyphs
package display_pkg;

   localparam logic [1:0] MODE_IDLE  = 2'b00;
   localparam logic [1:0] MODE_FILL  = 2'b01;
   localparam logic [1:0] MODE_CLEAN = 2'b10;
   localparam logic [1:0] MODE_FAULT = 2'b11;

   typedef enum logic [1:0] {
      S_MODE  = 2'd0,
      S_TENS  = 2'd1,
      S_UNITS = 2'd2
   } slot_e;

   // Bit 6 = g ... bit 0 = a, a low bit lights the segment
   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_L     = 7'b1000111;
   localparam logic [6:0] GLYPH_FAULT = 7'b0110111;

   function automatic logic [6:0] mode_glyph(input logic [1:0] m);
      case (m)
         MODE_FILL:  return GLYPH_E;
         MODE_CLEAN: return GLYPH_L;
         MODE_FAULT: return GLYPH_FAULT;
         default:    return GLYPH_DASH;
      endcase
   endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// rtl/bcd_display_scan_if.sv - counter digits and mode in, multiplexed display drive out
interface bcd_display_scan_if;
   logic [3:0] dz_bcd;
   logic [3:0] un_bcd;
   logic [1:0] mode;
   logic       done;
   logic [6:0] seg_n;
   logic [2:0] an_n;

   modport master (output dz_bcd, un_bcd, mode, done, input seg_n, an_n);
   modport slave  (input dz_bcd, un_bcd, mode, done, output seg_n, an_n);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-low glyph, dash for codes 10-15
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      case (bcd)
         4'd0:    seg_n = GLYPH_0;
         4'd1:    seg_n = GLYPH_1;
         4'd2:    seg_n = GLYPH_2;
         4'd3:    seg_n = GLYPH_3;
         4'd4:    seg_n = GLYPH_4;
         4'd5:    seg_n = GLYPH_5;
         4'd6:    seg_n = GLYPH_6;
         4'd7:    seg_n = GLYPH_7;
         4'd8:    seg_n = GLYPH_8;
         4'd9:    seg_n = GLYPH_9;
         default: seg_n = GLYPH_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - 3-digit common-anode scanner with per-frame input snapshot
// Optional end-of-cycle blinking enabled by defining BCD_DISPLAY_BLINK_EN.
module bcd_display_scan
   import display_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEAD_CYC     = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              clear_n,
   bcd_display_scan_if.slave disp
);

   localparam int PW = $clog2(SCAN_DIV);

   logic [PW-1:0] pcnt_q, pcnt_d;
   slot_e         slot_q, slot_d;
   logic [3:0]    dz_q, dz_d, un_q, un_d;
   logic [1:0]    mode_q, mode_d;
   logic [6:0]    seg_q, seg_d;
   logic [2:0]    an_q, an_d;
   logic [3:0]    digit;
   logic [6:0]    digit_seg;
   logic          slot_end;
   logic          frame_end;
   logic          dark;

   seg7_decode u_decode (
      .bcd   (digit),
      .seg_n (digit_seg)
   );

`ifdef BCD_DISPLAY_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   logic          done_q, done_d;
   logic          off_q, off_d;
   logic [BW-1:0] fcnt_q, fcnt_d;

   // Phase and count only advance while the snapshot says the timer has expired
   always_comb begin
      done_d = done_q;
      off_d  = off_q;
      fcnt_d = fcnt_q;
      if (frame_end) done_d = disp.done;
      if (!done_q) begin
         off_d  = 1'b0;
         fcnt_d = '0;
      end else if (frame_end) begin
         if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
            off_d  = ~off_q;
            fcnt_d = '0;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         done_q <= 1'b0;
         off_q  <= 1'b0;
         fcnt_q <= '0;
      end else begin
         done_q <= done_d;
         off_q  <= off_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign dark = off_q & done_q;
`else
   logic unused_done;
   localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
   assign unused_done = disp.done;
   assign dark        = 1'b0;
`endif

   assign slot_end  = (pcnt_q == PW'(SCAN_DIV - 1));
   assign frame_end = slot_end && (slot_q == S_UNITS);
   assign digit     = (slot_q == S_TENS) ? dz_q : un_q;

   always_comb begin
      pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
      slot_d = slot_q;
      if (slot_end) begin
         case (slot_q)
            S_MODE:  slot_d = S_TENS;
            S_TENS:  slot_d = S_UNITS;
            default: slot_d = S_MODE;
         endcase
      end

      dz_d   = dz_q;
      un_d   = un_q;
      mode_d = mode_q;
      if (frame_end) begin
         dz_d   = disp.dz_bcd;
         un_d   = disp.un_bcd;
         mode_d = disp.mode;
      end

      case (slot_q)
         S_MODE:  seg_d = mode_glyph(mode_q);
         S_TENS:  seg_d = (dz_q == 4'd0) ? GLYPH_BLANK : digit_seg;
         default: seg_d = digit_seg;
      endcase

      // Anodes stay dark for the first DEAD_CYC cycles so the previous glyph cannot ghost
      if (dark || (pcnt_q < PW'(DEAD_CYC))) begin
         an_d = 3'b111;
      end else begin
         case (slot_q)
            S_MODE:  an_d = 3'b110;
            S_TENS:  an_d = 3'b101;
            default: an_d = 3'b011;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         pcnt_q <= '0;
         slot_q <= S_MODE;
         dz_q   <= 4'd0;
         un_q   <= 4'd0;
         mode_q <= MODE_IDLE;
         seg_q  <= GLYPH_BLANK;
         an_q   <= 3'b111;
      end else begin
         pcnt_q <= pcnt_d;
         slot_q <= slot_d;
         dz_q   <= dz_d;
         un_q   <= un_d;
         mode_q <= mode_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
      end
   end

   assign disp.seg_n = seg_q;
   assign disp.an_n  = an_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - scoreboard bench: expected slot activations queued, monitor checks each
module tb_bcd_display_scan;

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010, G7 = 7'b1111000, G8 = 7'b0000000, G9 = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111, BLANK = 7'b1111111, GE = 7'b0000110;
   localparam logic [6:0] GL = 7'b1000111, GF = 7'b0110111;

   typedef struct {
      int         k;
      logic [2:0] an;
      logic [6:0] seg;
   } exp_t;

   logic clk = 1'b0;
   logic clear_n;
   int   cyc;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q[$];

   bcd_display_scan_if dif ();

   bcd_display_scan #(
      .SCAN_DIV     (4),
      .DEAD_CYC     (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .disp    (dif)
   );

   always #5 clk = ~clk;

   // Cycle number since reset release: after posedge k, cyc == k
   always @(posedge clk or negedge clear_n) begin
      if (!clear_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int m, input logic [6:0] sm, input logic [6:0] st,
                             input logic [6:0] su);
      q.push_back('{k: 12*m + 2,  an: 3'b110, seg: sm});
      q.push_back('{k: 12*m + 6,  an: 3'b101, seg: st});
      q.push_back('{k: 12*m + 10, an: 3'b011, seg: su});
   endtask

   task automatic wait_cyc(input int n);
      do @(negedge clk); while (cyc != n);
      #2;
   endtask

   // Monitor: every rising edge of an anode (111 -> active) is one slot presentation
   initial begin
      logic [2:0] prev_an;
      logic [6:0] prev_seg;
      exp_t e;
      prev_an  = 3'b111;
      prev_seg = 7'h7f;
      forever begin
         @(negedge clk);
         if (clear_n && prev_an == 3'b111 && dif.an_n != 3'b111) begin
            if (q.size() == 0) begin
               check("unexpected_slot", {29'd0, dif.an_n}, 32'd7);
            end else begin
               e = q.pop_front();
               check("slot_cycle", cyc, e.k);
               check("slot_an", {29'd0, dif.an_n}, {29'd0, e.an});
               check("slot_seg", {25'd0, dif.seg_n}, {25'd0, e.seg});
               check("dead_seg", {25'd0, prev_seg}, {25'd0, e.seg});
            end
         end
         prev_an  = dif.an_n;
         prev_seg = dif.seg_n;
      end
   end

   initial begin
      clear_n     = 1'b0;
      dif.dz_bcd  = 4'd2;
      dif.un_bcd  = 4'd7;
      dif.mode    = 2'b01;
      dif.done    = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      check("reset_an", {29'd0, dif.an_n}, 32'd7);
      check("reset_seg", {25'd0, dif.seg_n}, 32'h7f);

      push_frame(0, DASH, BLANK, G0);
      push_frame(1, GE, G2, G7);
      push_frame(2, GE, G2, G7);
      push_frame(3, GE, G2, G3);
      push_frame(4, GL, BLANK, DASH);
      push_frame(5, GF, DASH, G9);
      push_frame(6, DASH, G8, G0);
      push_frame(7, DASH, G8, G0);
      clear_n = 1'b1;

      wait_cyc(29);
      dif.un_bcd = 4'd3;
      wait_cyc(47);
      dif.dz_bcd = 4'd0; dif.un_bcd = 4'd12; dif.mode = 2'b10;
      wait_cyc(59);
      dif.dz_bcd = 4'd15; dif.un_bcd = 4'd9; dif.mode = 2'b11;
      // Driven in the capture cycle itself, so frame 6 must pick it up
      wait_cyc(71);
      dif.dz_bcd = 4'd8; dif.un_bcd = 4'd0; dif.mode = 2'b00;

      wait_cyc(94);
      clear_n = 1'b0;
      #1;
      check("midscan_reset_an", {29'd0, dif.an_n}, 32'd7);
      check("midscan_reset_seg", {25'd0, dif.seg_n}, 32'h7f);
      check("pending_before_release", q.size(), 0);

      dif.dz_bcd = 4'd1; dif.un_bcd = 4'd5; dif.mode = 2'b01;
      repeat (2) @(negedge clk);
      #2;
      push_frame(0, DASH, BLANK, G0);
      push_frame(1, GE, G1, G5);
      push_frame(2, GE, G1, G5);
      push_frame(3, GE, G1, G5);
`ifndef BCD_DISPLAY_BLINK_EN
      push_frame(4, GE, G1, G5);
      push_frame(5, GE, G1, G5);
`endif
      push_frame(6, GE, G1, G5);
      push_frame(7, GE, G1, G5);
      push_frame(8, GE, G1, G5);
      push_frame(9, GE, G1, G5);
      clear_n = 1'b1;

      wait_cyc(23);
      dif.done = 1'b1;
      wait_cyc(95);
      dif.done = 1'b0;
      wait_cyc(120);
      check("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Multiplexed seven-segment scanner for the irrigation timer's status display. It reads the seconds counters' BCD digits (tens and units) plus the current fill/clean mode and drives a 3-digit common-anode display: mode glyph, tens, units. It is the consumer end of the counter digit outputs. Inputs are snapshotted once per frame, so a digit never tears mid-scan. It also provides leading-zero blanking, anode dead time and optional end-of-cycle blinking.

## Interface
- SCAN_DIV, 1000: clock cycles each digit slot is active; must be ≥ 2.
- DEAD_CYC, 2: cycles at the start of each slot with all anodes off (anti-ghosting); must be < SCAN_DIV.
- BLINK_FRAMES, 64: frames per blink half-period; used only with the blink feature.

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  reset, asynchronous, active-low.
- dz_bcd  in  4  tens-of-seconds digit, bit 3 = MSB.
- un_bcd  in  4  units-of-seconds digit.
- mode  in  2  mode select: 00 idle, 01 fill (enchimento), 10 clean (limpeza), 11 fault.
- done  in  1  timer expired, level.
- seg_n  out  7  segments, active-low, bit0 = a … bit6 = g; registered.
- an_n  out  3  anode enables, active-low, bit0 = mode digit, bit1 = tens, bit2 = units; registered.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps. A slot ends on the cycle where pcnt = SCAN_DIV-1.
- Slot index FSM: S_MODE → S_TENS → S_UNITS → S_MODE. Each transition happens at slot end.
- A frame is S_MODE..S_UNITS, 3·SCAN_DIV cycles.
- Shadow capture:
  - On the transition S_UNITS → S_MODE, dz_bcd, un_bcd, mode and done are registered into the shadow registers.
  - All display content comes from the shadow registers only.
- Glyphs for digits 0–9 use the standard patterns. For example:
  - 0 = 1000000
  - 7 = 1111000
  - 8 = 0000000
- Mode glyph (seg_n):
  - idle: dash, 0111111
  - fill: E, 0000110
  - clean: L, 1000111
  - fault: dash with d also lit, 0110111
- Invalid BCD (10–15) on either digit displays a dash (0111111).
- Leading-zero blanking: shadow tens = 0 blanks the tens digit (seg_n = 1111111). The units digit is never blanked.
- Anode drive:
  - an_n has exactly the current slot's bit low, except during the first DEAD_CYC cycles of every slot, when an_n = 111.
  - seg_n updates at slot start. It is valid throughout the dead time.

## Timing
- Reset values (immediate, asynchronous):
  - an_n = 111, seg_n = 1111111
  - pcnt = 0, slot = S_MODE
  - shadow digits = 0, shadow mode = idle, shadow done = 0
  - blink phase = on
- First post-reset frame shows the reset shadow values: dash, blank, 0.
- Input-to-display latency: a value held stable across a frame boundary appears in the next frame, i.e. ≤ 3·SCAN_DIV + 1 cycles.
- Inputs changing mid-frame are ignored until the next capture edge. Changes within the capture cycle itself are sampled by the capture.
- Outputs are registered, one cycle behind the slot/pcnt state.
- Reset asserted mid-slot forces the reset values at once. On release, scanning restarts at S_MODE with pcnt = 0.

## Configuration
- `BCD_DISPLAY_BLINK_EN` defined:
  - While shadow done = 1, a frame counter toggles the blink phase every BLINK_FRAMES frames.
  - During the off phase an_n = 111 for the whole frame.
  - Shadow done = 0 forces phase = on and clears the frame counter.
- Not defined: done is ignored and no blink logic is synthesised.

## Structure
- Shared package `display_pkg`:
  - mode encoding constants
  - slot index typedef (S_MODE/S_TENS/S_UNITS)
  - glyph constants: digits 0–9, DASH, BLANK, E, L, FAULT
- Sub-module `seg7_decode`: combinational 4-bit BCD → 7-bit active-low glyph, with a dash for invalid codes. It is instantiated once on the muxed shadow digit.

## Test plan
- Reset: hold clear_n = 0 → an_n = 111, seg_n = 1111111. Release with SCAN_DIV = 4, DEAD_CYC = 1 → first frame shows mode dash, tens blank, units seg_n = 1000000.
- Display digits: dz = 2, un = 7, mode = 01 held → next frame:
  - an_n 110 with seg_n 0000110
  - then 101 with the "2" glyph 0100100
  - then 011 with 1111000
  - each slot preceded by 1 cycle of an_n = 111
- Tearing: change un from 7 to 3 at S_TENS mid-frame → the current frame's units slot still shows 7; the following frame shows 3 (0110000).
- Invalid BCD and blanking: dz = 0, un = 12 → tens slot seg_n = 1111111, units slot seg_n = 0111111.
- Mid-scan reset: assert clear_n low at pcnt = 2 of S_UNITS → outputs are at reset values in the same cycle; after release, the first active anode is bit0 after DEAD_CYC cycles.
- Blink (macro defined, BLINK_FRAMES = 2): done = 1 → frames alternate 2 on / 2 with an_n = 111 throughout; done = 0 → steady display from the next frame.
